// File: rtl/axis_pair_join_if.sv
// Bus bundle for axis_pair_join: two 128-bit input lanes and the joined 256-bit output.
// Every channel uses AXI4-Stream valid/ready: a beat transfers on the rising edge where
// both TVALID and TREADY are 1; a source holds TVALID and TDATA stable until that edge.
interface axis_pair_join_if #(
    parameter int DATA_W = 128
);
    logic                S0_AXIS_TVALID;
    logic                S0_AXIS_TREADY;
    logic [DATA_W-1:0]   S0_AXIS_TDATA;
    logic                S1_AXIS_TVALID;
    logic                S1_AXIS_TREADY;
    logic [DATA_W-1:0]   S1_AXIS_TDATA;
    logic                M_AXIS_TVALID;
    logic                M_AXIS_TREADY;
    logic [2*DATA_W-1:0] M_AXIS_TDATA;

    // Traffic side: drives both input lanes and the downstream ready.
    modport master (
        output S0_AXIS_TVALID, S0_AXIS_TDATA,
        output S1_AXIS_TVALID, S1_AXIS_TDATA,
        output M_AXIS_TREADY,
        input  S0_AXIS_TREADY, S1_AXIS_TREADY,
        input  M_AXIS_TVALID, M_AXIS_TDATA
    );

    // Join side: accepts both lanes and presents the joined beat.
    modport slave (
        input  S0_AXIS_TVALID, S0_AXIS_TDATA,
        input  S1_AXIS_TVALID, S1_AXIS_TDATA,
        input  M_AXIS_TREADY,
        output S0_AXIS_TREADY, S1_AXIS_TREADY,
        output M_AXIS_TVALID, M_AXIS_TDATA
    );
endinterface

// File: rtl/axis_pair_join.sv
// Two-lane AXI4-Stream join: each lane is buffered in its own FIFO and one {lane1, lane0}
// beat leaves only when both lanes hold data, so the n-th beats of the two lanes always pair.
module axis_pair_join #(
    parameter int  DATA_W     = 128,
    parameter int  FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    axis_pair_join_if.slave  axis,
    output logic [OCC_W-1:0] OCC0,
    output logic [OCC_W-1:0] OCC1,
    output logic [31:0]      PAIR_CNT
);

    logic                         init_done;
    logic [1:0]                   lane_valid;
    logic [1:0]                   lane_ready;
    logic [1:0]                   push;
    logic [1:0][DATA_W-1:0]       lane_data;
    logic [1:0][DATA_W-1:0]       head;
    logic [1:0][OCC_W-1:0]        occ_q;
    logic                         m_valid;
    logic                         pop;
    logic [31:0]                  pair_cnt_q;

    assign lane_valid = {axis.S1_AXIS_TVALID, axis.S0_AXIS_TVALID};
    assign lane_data  = {axis.S1_AXIS_TDATA, axis.S0_AXIS_TDATA};

    // Keeps TREADY low for the first cycle after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Output valid comes only from registered occupancies, never from the input valids.
    assign m_valid = (occ_q[0] != '0) && (occ_q[1] != '0);
    assign pop     = m_valid && axis.M_AXIS_TREADY;

    for (genvar k = 0; k < 2; k++) begin : g_lane
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [OCC_W-1:0]  occ;

        // Ready looks only at this lane's own fill level, so a full lane
        // stays stalled through a same-cycle pop.
        assign lane_ready[k] = init_done && (occ != OCC_W'(FIFO_DEPTH));
        assign push[k]       = lane_valid[k] && lane_ready[k];
        assign head[k]       = mem[rd_ptr];
        assign occ_q[k]      = occ;

        // Storage is deliberately left unreset; occupancy alone marks entries valid.
        always_ff @(posedge aclk) begin
            if (push[k]) begin
                mem[wr_ptr] <= lane_data[k];
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[k]) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push[k], pop})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pair_cnt_q <= '0;
        end else if (pop) begin
            pair_cnt_q <= pair_cnt_q + 32'd1;
        end
    end

    assign axis.S0_AXIS_TREADY = lane_ready[0];
    assign axis.S1_AXIS_TREADY = lane_ready[1];
    assign axis.M_AXIS_TVALID  = m_valid;
    assign axis.M_AXIS_TDATA   = {head[1], head[0]};
    assign OCC0                = occ_q[0];
    assign OCC1                = occ_q[1];
    assign PAIR_CNT            = pair_cnt_q;

endmodule

// File: tb/tb_axis_pair_join.sv
// Bench for axis_pair_join: per-lane queues model the join, plus a hand-computed
// skew table and directed reset, lockstep, stall and mid-run reset sequences.
module tb_axis_pair_join;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;
    localparam int OCC_W  = 3;

    logic             aclk    = 1'b0;
    logic             aresetn = 1'b0;
    logic [OCC_W-1:0] occ0;
    logic [OCC_W-1:0] occ1;
    logic [31:0]      pair_cnt;

    axis_pair_join_if #(.DATA_W(DATA_W)) bus ();

    axis_pair_join #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .axis     (bus),
        .OCC0     (occ0),
        .OCC1     (occ1),
        .PAIR_CNT (pair_cnt)
    );

    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [2*DATA_W-1:0] act,
                       input logic [2*DATA_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: one queue per lane, a join counter and the init flag.
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    int unsigned       m_cnt  = 0;
    bit                m_init = 1'b0;
    bit                e_r0, e_r1, e_mv;
    bit                h0, h1, hp;
    logic [DATA_W-1:0] seq0 = '0;
    logic [DATA_W-1:0] seq1 = '0;
    bit                rand_data = 1'b0;

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [DATA_W-1:0] next_data(input logic [DATA_W-1:0] cur);
        return rand_data ? rnd128() : cur + 1'b1;
    endfunction

    // First half of a cycle: drive inputs, then check outputs at the falling edge.
    task automatic cyc_a(input bit v0, input bit v1, input bit mr);
        bus.S0_AXIS_TVALID = v0;
        bus.S0_AXIS_TDATA  = seq0;
        bus.S1_AXIS_TVALID = v1;
        bus.S1_AXIS_TDATA  = seq1;
        bus.M_AXIS_TREADY  = mr;
        @(negedge aclk);
        e_r0 = m_init && (q0.size() < DEPTH);
        e_r1 = m_init && (q1.size() < DEPTH);
        e_mv = (q0.size() != 0) && (q1.size() != 0);
        chk("s0_tready", bus.S0_AXIS_TREADY, e_r0);
        chk("s1_tready", bus.S1_AXIS_TREADY, e_r1);
        chk("m_tvalid", bus.M_AXIS_TVALID, e_mv);
        chk("occ0", occ0, q0.size());
        chk("occ1", occ1, q1.size());
        chk("pair_cnt", pair_cnt, m_cnt);
        if (e_mv) chk("m_tdata", bus.M_AXIS_TDATA, {q1[0], q0[0]});
        h0 = v0 && e_r0;
        h1 = v1 && e_r1;
        hp = e_mv && mr;
    endtask

    // Second half: advance the model on the rising edge.
    task automatic cyc_b();
        @(posedge aclk);
        if (!aresetn) begin
            q0.delete();
            q1.delete();
            m_cnt  = 0;
            m_init = 1'b0;
        end else begin
            if (hp) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                m_cnt++;
            end
            if (h0) begin
                q0.push_back(seq0);
                seq0 = next_data(seq0);
            end
            if (h1) begin
                q1.push_back(seq1);
                seq1 = next_data(seq1);
            end
            m_init = 1'b1;
        end
        #1;
    endtask

    task automatic cycle(input bit v0, input bit v1, input bit mr);
        cyc_a(v0, v1, mr);
        cyc_b();
    endtask

    typedef struct {
        bit             v0, v1, mr;
        bit             r0, r1, mv;
        logic [OCC_W-1:0] o0, o1;
    } vec_t;
    vec_t tbl[14];

    function automatic vec_t mk(bit v0, bit v1, bit mr, bit r0, bit r1, bit mv,
                                int o0, int o1);
        vec_t t;
        t.v0 = v0; t.v1 = v1; t.mr = mr;
        t.r0 = r0; t.r1 = r1; t.mv = mv;
        t.o0 = OCC_W'(o0); t.o1 = OCC_W'(o1);
        return t;
    endfunction

    initial begin
        logic [2*DATA_W-1:0] exp_beat;
        int                  thr;

        // Skew: lane 0 fills to 4 alone, then lane 1 supplies A..F.
        tbl[0]  = mk(1, 0, 1, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 1, 1, 0, 1, 0);
        tbl[2]  = mk(1, 0, 1, 1, 1, 0, 2, 0);
        tbl[3]  = mk(1, 0, 1, 1, 1, 0, 3, 0);
        tbl[4]  = mk(1, 0, 1, 0, 1, 0, 4, 0);
        tbl[5]  = mk(1, 0, 1, 0, 1, 0, 4, 0);
        tbl[6]  = mk(1, 1, 1, 0, 1, 0, 4, 0);
        tbl[7]  = mk(1, 1, 1, 0, 1, 1, 4, 1);
        tbl[8]  = mk(1, 1, 1, 1, 1, 1, 3, 1);
        tbl[9]  = mk(1, 1, 1, 1, 1, 1, 3, 1);
        tbl[10] = mk(0, 1, 1, 1, 1, 1, 3, 1);
        tbl[11] = mk(0, 1, 1, 1, 1, 1, 2, 1);
        tbl[12] = mk(0, 0, 1, 1, 1, 1, 1, 1);
        tbl[13] = mk(0, 0, 1, 1, 1, 0, 0, 0);

        // Reset held 5 cycles with both valids high.
        aresetn = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1, 1, 0);
        chk("rst_s0_tready", bus.S0_AXIS_TREADY, 1'b0);
        chk("rst_m_tvalid", bus.M_AXIS_TVALID, 1'b0);
        chk("rst_pair_cnt", pair_cnt, 32'd0);
        aresetn = 1'b1;
        cyc_a(1, 1, 0);
        chk("init_tready0_low", bus.S0_AXIS_TREADY, 1'b0);
        chk("init_tready1_low", bus.S1_AXIS_TREADY, 1'b0);
        cyc_b();
        chk("init_no_accept", occ0, 3'd0);
        chk("init_tready0_high", bus.S0_AXIS_TREADY, 1'b1);
        cycle(0, 0, 0);

        // Lockstep 1..16 with downstream always ready.
        seq0 = 128'd1;
        seq1 = 128'd1;
        for (int i = 0; i < 16; i++) begin
            cyc_a(1, 1, 1);
            chk("lock_valid", bus.M_AXIS_TVALID, i >= 1);
            if (i >= 1) begin
                exp_beat = {DATA_W'(i), DATA_W'(i)};
                chk("lock_data", bus.M_AXIS_TDATA, exp_beat);
            end
            cyc_b();
        end
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("lock_pair_cnt", pair_cnt, 32'd16);

        // Skew table.
        seq0 = 128'd1;
        seq1 = 128'hA;
        for (int r = 0; r < 14; r++) begin
            cyc_a(tbl[r].v0, tbl[r].v1, tbl[r].mr);
            chk("tbl_s0_tready", bus.S0_AXIS_TREADY, tbl[r].r0);
            chk("tbl_s1_tready", bus.S1_AXIS_TREADY, tbl[r].r1);
            chk("tbl_m_tvalid", bus.M_AXIS_TVALID, tbl[r].mv);
            chk("tbl_occ0", occ0, tbl[r].o0);
            chk("tbl_occ1", occ1, tbl[r].o1);
            if (r == 7) chk("tbl_first_pair", bus.M_AXIS_TDATA, {128'hA, 128'h1});
            if (r == 12) chk("tbl_last_pair", bus.M_AXIS_TDATA, {128'hF, 128'h6});
            cyc_b();
        end
        chk("skew_pair_cnt", pair_cnt, 32'd22);

        // Downstream stall for 10 cycles, then drain.
        seq0 = 128'h100;
        seq1 = 128'h200;
        for (int i = 0; i < 10; i++) cycle(1, 1, 0);
        chk("stall_occ0", occ0, 3'd4);
        chk("stall_occ1", occ1, 3'd4);
        chk("stall_tready0", bus.S0_AXIS_TREADY, 1'b0);
        chk("stall_tready1", bus.S1_AXIS_TREADY, 1'b0);
        chk("stall_head", bus.M_AXIS_TDATA, {128'h200, 128'h100});
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);
        chk("stall_pair_cnt", pair_cnt, 32'd26);

        // Mid-run reset with OCC0=3, OCC1=1.
        seq0 = 128'h300;
        seq1 = 128'h400;
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("pre_rst_occ0", occ0, 3'd3);
        chk("pre_rst_occ1", occ1, 3'd1);
        #1;
        aresetn = 1'b0;
        q0.delete();
        q1.delete();
        m_cnt  = 0;
        m_init = 1'b0;
        #1;
        chk("async_rst_occ0", occ0, 3'd0);
        chk("async_rst_occ1", occ1, 3'd0);
        chk("async_rst_m_tvalid", bus.M_AXIS_TVALID, 1'b0);
        chk("async_rst_tready", bus.S0_AXIS_TREADY, 1'b0);
        chk("async_rst_pair_cnt", pair_cnt, 32'd0);
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        aresetn = 1'b1;
        cycle(0, 0, 1);
        seq0 = 128'h500;
        seq1 = 128'h600;
        cycle(1, 1, 1);
        cyc_a(0, 0, 1);
        chk("rst_first_beat", bus.M_AXIS_TDATA, {128'h600, 128'h500});
        cyc_b();

        // Random stress against the queue model.
        rand_data = 1'b1;
        seq0 = rnd128();
        seq1 = rnd128();
        for (int i = 0; i < 10000; i++) begin
            thr = ((i / 1000) % 2 == 1) ? 30 : 90;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) < thr);
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 1);
        chk("final_pair_cnt", pair_cnt, m_cnt);
        chk("final_occ0", occ0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
